// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with internal baud divider.
// Sends one word per accepted request as start bit, DATA_BITS data bits (LSB
// first), an optional parity bit and STOP_BITS stop bits; each bit lasts
// CLKS_PER_BIT clocks.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous reset, active-low
//   start    - request valid; accepted when start && ready
//   data_in  - word to send, sampled on the accept cycle only
//   ready    - idle, can accept a request
//   busy     - frame in progress (always !ready)
//   done     - one-cycle pulse in the last clock of the final stop bit
//   tx       - registered serial line, idle high
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    // Elaboration-time parameter legality checks
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY=%0d is illegal (0 none, 1 odd, 2 even)", PARITY);
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS=%0d out of range 5..9", DATA_BITS);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT=%0d out of range 2..65535", CLKS_PER_BIT);
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx is computed for the state being entered so the
    // line register changes exactly on bit boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    shift_d = data_in;
                    par_d   = (PARITY == 1) ? ~^data_in : ^data_in;
                    state_d = ST_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Shift so the next data bit is always at position 0
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Status outputs are registered from the next-state values
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_STOP) && (cnt_d == CNT_LAST) && (stop_d == STOP_LAST);
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tx    = tx_q;

endmodule
